// File: rtl/morse_keyer.sv
// Buffered Morse keyer: a small FIFO of (pattern, length, gap) entries keyed out MSB-first,
// one unit per UNIT_CYCLES clocks using a prescaler clock enable.
module morse_keyer #(
  parameter int unsigned PAT_W       = 20,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned UNIT_CYCLES = 3000000,
  parameter int unsigned LETTER_GAP  = 3,
  parameter int unsigned WORD_GAP    = 7,
  localparam int unsigned LEN_W      = $clog2(PAT_W + 1),
  localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic [1:0]       i_gap,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_abort,
  output logic             o_key,
  output logic             o_busy,
  output logic             o_done,
  output logic [LVL_W-1:0] o_level
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned MAX_GU = (LETTER_GAP > WORD_GAP) ? LETTER_GAP : WORD_GAP;
  localparam int unsigned MAX_U  = (PAT_W > MAX_GU) ? PAT_W : MAX_GU;
  localparam int unsigned CNT_W  = $clog2(MAX_U + 1);
  localparam int unsigned PRE_W  = $clog2(UNIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StLoad, StSymbol, StGap} state_e;

  // Queue storage and pointers (extra MSB distinguishes full from empty)
  logic [PAT_W-1:0] pat_mem [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic [1:0]       gap_mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             empty, full, push, pop;
  logic [LEN_W-1:0] len_clamped;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign o_ready = !full;
  assign o_level = LVL_W'(wr_ptr_q - rd_ptr_q);
  assign push    = i_valid && !full && !i_abort;
  assign len_clamped = (i_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : i_len;

  always_ff @(posedge i_clk) begin
    if (push) begin
      pat_mem[wr_ptr_q[PTR_W-1:0]] <= i_pattern;
      len_mem[wr_ptr_q[PTR_W-1:0]] <= len_clamped;
      gap_mem[wr_ptr_q[PTR_W-1:0]] <= i_gap;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (i_abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Head entry decode, shared by LOAD and the bubble-free chained load
  logic [PAT_W-1:0] head_pat;
  logic [LEN_W-1:0] head_len;
  logic [1:0]       head_gap;
  state_e           ld_state;
  logic [CNT_W-1:0] ld_cnt;

  function automatic logic [CNT_W-1:0] gap_units(input logic [1:0] g);
    if (g == 2'b00)      return '0;
    else if (g == 2'b01) return CNT_W'(LETTER_GAP);
    else                 return CNT_W'(WORD_GAP);
  endfunction

  assign head_pat = pat_mem[rd_ptr_q[PTR_W-1:0]];
  assign head_len = len_mem[rd_ptr_q[PTR_W-1:0]];
  assign head_gap = gap_mem[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    ld_state = StIdle;
    ld_cnt   = gap_units(head_gap);
    if (head_len != '0) begin
      ld_state = StSymbol;
      ld_cnt   = CNT_W'(head_len);
    end else if (head_gap != 2'b00) begin
      ld_state = StGap;
    end
  end

  // Keyer FSM
  state_e           state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gap_q, gap_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             key_q, key_d, done_q, done_d;
  logic             active, tick, end_entry;

  assign active = (state_q == StSymbol) || (state_q == StGap);
  assign tick   = active && (presc_q == PRE_W'(UNIT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    end_entry = 1'b0;
    unique case (state_q)
      StIdle: if (!empty) state_d = StLoad;
      StLoad: begin
        pop     = 1'b1;
        shift_d = head_pat;
        gap_d   = head_gap;
        cnt_d   = ld_cnt;
        state_d = ld_state;
        if (ld_state == StIdle) done_d = 1'b1;
      end
      StSymbol: if (tick) begin
        shift_d = shift_q << 1;
        if (cnt_q == CNT_W'(1)) begin
          if (gap_q != 2'b00) begin
            state_d = StGap;
            cnt_d   = gap_units(gap_q);
          end else begin
            end_entry = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StGap: if (tick) begin
        if (cnt_q == CNT_W'(1)) end_entry = 1'b1;
        else                    cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = StIdle;
    endcase
    // Zero-length heads are left for the LOAD path so they still get their own done pulse
    if (end_entry) begin
      done_d = 1'b1;
      if (!empty && (ld_state != StIdle)) begin
        pop     = 1'b1;
        shift_d = head_pat;
        gap_d   = head_gap;
        cnt_d   = ld_cnt;
        state_d = ld_state;
      end else begin
        state_d = StIdle;
      end
    end
    if (i_abort) begin
      state_d = StIdle;
      pop     = 1'b0;
      done_d  = 1'b0;
    end
    key_d   = (state_d == StSymbol) && shift_d[PAT_W-1];
    presc_d = (active && !tick && !i_abort) ? presc_q + PRE_W'(1) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      presc_q <= '0;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      presc_q <= presc_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign o_key  = key_q;
  assign o_done = done_q;
  assign o_busy = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES=4; all timing indices are counted in
// negedge samples, sample 0 being the first negedge after the push edge.
module tb_morse_keyer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [1:0]  gap = '0;
  logic        valid = 1'b0;
  logic        abort = 1'b0;
  logic        ready, key, busy, done;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  morse_keyer #(
    .PAT_W(20), .DEPTH(4), .UNIT_CYCLES(4), .LETTER_GAP(3), .WORD_GAP(7)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pattern(pattern), .i_len(len), .i_gap(gap),
    .i_valid(valid), .o_ready(ready), .i_abort(abort), .o_key(key), .o_busy(busy),
    .o_done(done), .o_level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic push(input logic [19:0] p, input logic [4:0] l, input logic [1:0] g);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_ready_timeout", 64'(ready), 64'd1);
    pattern = p;
    len     = l;
    gap     = g;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
  endtask

  task automatic capture(input int n, output logic [63:0] kv, output int kcnt, output int dcnt,
                         output int dfirst, output int dlast);
    kv = '0; kcnt = 0; dcnt = 0; dfirst = -1; dlast = -1;
    for (int i = 0; i < n; i++) begin
      if (key === 1'b1) begin
        kcnt++;
        if (i < 64) kv[i] = 1'b1;
      end
      if (done === 1'b1) begin
        if (dcnt == 0) dfirst = i;
        dlast = i;
        dcnt++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] kv;
    int kcnt, dcnt, dfirst, dlast;

    // Reset state, then hold idle for 10 cycles
    #2;
    check("rst_key", 64'(key), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_key", 64'(key), 64'd0);
      check("idle_ready", 64'(ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_level", 64'(level), 64'd0);
      check("idle_done", 64'(done), 64'd0);
    end

    // B8000 len 5: LOAD at s1, key 4x1 4x0 12x1 over s2..s21, done at s22
    push(20'hB8000, 5'd5, 2'b00);
    capture(40, kv, kcnt, dcnt, dfirst, dlast);
    check("g0_wave", kv, 64'h3F_FC3C);
    check("g0_keycnt", 64'(kcnt), 64'd16);
    check("g0_donecnt", 64'(dcnt), 64'd1);
    check("g0_donepos", 64'(dfirst), 64'd22);
    check("g0_busy_end", 64'(busy), 64'd0);

    // Letter gap: 12 extra low cycles
    push(20'hB8000, 5'd5, 2'b01);
    capture(60, kv, kcnt, dcnt, dfirst, dlast);
    check("g1_wave", kv, 64'h3F_FC3C);
    check("g1_donecnt", 64'(dcnt), 64'd1);
    check("g1_donepos", 64'(dfirst), 64'd34);

    // Word gap: 28 extra low cycles
    push(20'hB8000, 5'd5, 2'b10);
    capture(70, kv, kcnt, dcnt, dfirst, dlast);
    check("g2_keycnt", 64'(kcnt), 64'd16);
    check("g2_donecnt", 64'(dcnt), 64'd1);
    check("g2_donepos", 64'(dfirst), 64'd50);

    // Length above PAT_W clamps to 20 units
    push(20'hFFFFF, 5'd31, 2'b00);
    capture(100, kv, kcnt, dcnt, dfirst, dlast);
    check("clamp_keycnt", 64'(kcnt), 64'd80);
    check("clamp_donepos", 64'(dfirst), 64'd82);

    // Five back-to-back pushes: first pop at E2, queue fills on the 5th
    for (int i = 0; i < 5; i++) push(20'hB8000, 5'd5, 2'b00);
    check("b2b_level", 64'(level), 64'd4);
    check("b2b_ready", 64'(ready), 64'd0);
    // Capture starts at s4 of the first entry; dones every 20 cycles from s22
    capture(120, kv, kcnt, dcnt, dfirst, dlast);
    check("b2b_donecnt", 64'(dcnt), 64'd5);
    check("b2b_first", 64'(dfirst), 64'd18);
    check("b2b_last", 64'(dlast), 64'd98);
    check("b2b_keycnt", 64'(kcnt), 64'd78);
    check("b2b_busy_end", 64'(busy), 64'd0);

    // Abort in the 2nd unit with 3 entries queued; the offered entry is dropped
    for (int i = 0; i < 4; i++) push(20'hFFFFF, 5'd5, 2'b00);
    check("ab_level_pre", 64'(level), 64'd3);
    repeat (4) @(negedge clk);
    check("ab_key_pre", 64'(key), 64'd1);
    abort = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    valid = 1'b0;
    check("ab_key", 64'(key), 64'd0);
    check("ab_level", 64'(level), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_ready", 64'(ready), 64'd1);
    capture(60, kv, kcnt, dcnt, dfirst, dlast);
    check("ab_donecnt", 64'(dcnt), 64'd0);
    check("ab_keycnt", 64'(kcnt), 64'd0);

    // Asynchronous reset mid-GAP (gap covers s22..s33)
    push(20'hB8000, 5'd5, 2'b01);
    repeat (26) @(negedge clk);
    check("rg_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rg_busy", 64'(busy), 64'd0);
    check("rg_key", 64'(key), 64'd0);
    check("rg_level", 64'(level), 64'd0);
    check("rg_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    capture(30, kv, kcnt, dcnt, dfirst, dlast);
    check("rg_donecnt", 64'(dcnt), 64'd0);

    // Asynchronous reset mid-symbol drops the key before the next edge
    push(20'hFFFFF, 5'd5, 2'b00);
    repeat (4) @(negedge clk);
    check("rs_key_pre", 64'(key), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_key", 64'(key), 64'd0);
    check("rs_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    capture(30, kv, kcnt, dcnt, dfirst, dlast);
    check("rs_donecnt", 64'(dcnt), 64'd0);

    // len=0, gap=00: LOAD at s1, done at s2, key never set
    push(20'hFFFFF, 5'd0, 2'b00);
    capture(10, kv, kcnt, dcnt, dfirst, dlast);
    check("z_keycnt", 64'(kcnt), 64'd0);
    check("z_donecnt", 64'(dcnt), 64'd1);
    check("z_donepos", 64'(dfirst), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
